csa_mult_pipe: RTL



---
 rtl/csa_mult_pipe.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/csa_mult_pipe.sv
// csa_mult_pipe: three-stage pipelined WIDTH x WIDTH multiplier, unsigned or
// two's-complement per beat.
//   S0: operand capture
//   S1: partial products (Baugh-Wooley sign handling) reduced by a chain of
//       3:2 carry-save compressors to sum/carry rows
//   S2: carry-propagate add into out_z
// All stages advance together whenever the output slot is free or retiring.
// Optional feature macro: CSA_MULT_PIPE_ACC_EN adds in_acc/in_acc_clr and a
// 2*WIDTH-bit accumulator applied at S2.
module csa_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
`ifdef CSA_MULT_PIPE_ACC_EN
  input  logic                 in_acc,
  input  logic                 in_acc_clr,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_z,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int ZW = 2 * WIDTH;
  localparam logic [ZW-1:0] ONE = ZW'(1);
  // Baugh-Wooley correction: +2^W and +2^(2W-1), the latter being -2^(2W-1) mod 2^(2W)
  localparam logic [ZW-1:0] BW_CONST = (ONE << WIDTH) | (ONE << (ZW - 1));

  logic adv;

  logic             s0_valid;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  logic             s0_signed;
  logic [TAG_W-1:0] s0_tag;

  logic             s1_valid;
  logic [ZW-1:0]    s1_sum;
  logic [ZW-1:0]    s1_carry;
  logic [TAG_W-1:0] s1_tag;

  logic [ZW-1:0]    prod;
  logic [ZW-1:0]    z_next;
  logic [ZW-1:0]    red_sum;
  logic [ZW-1:0]    red_carry;

`ifdef CSA_MULT_PIPE_ACC_EN
  logic             s0_acc;
  logic             s0_clr;
  logic             s1_acc;
  logic             s1_clr;
  logic [ZW-1:0]    acc_q;
  logic [ZW-1:0]    acc_next;
`endif

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Partial-product matrix: WIDTH shifted rows plus one correction-constant row.
  // In signed mode the cross terms that involve exactly one sign bit are inverted.
  logic [WIDTH-1:0] pp_bits [WIDTH];
  logic [ZW-1:0]    pp_row  [WIDTH+1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    localparam logic [WIDTH-1:0] INV = (i == WIDTH - 1) ?
                                       {1'b0, {(WIDTH-1){1'b1}}} :
                                       {1'b1, {(WIDTH-1){1'b0}}};
    assign pp_bits[i] = (s0_a & {WIDTH{s0_b[i]}}) ^ (s0_signed ? INV : '0);
    assign pp_row[i]  = {{WIDTH{1'b0}}, pp_bits[i]} << i;
  end

  assign pp_row[WIDTH] = s0_signed ? BW_CONST : '0;

  // Carry-save reduction: each level folds one more row into the sum/carry pair.
  // Carries shifted out of the top bit are dropped, which is exact modulo 2^(2W).
  for (genvar k = 0; k < WIDTH - 1; k++) begin : g_csa
    logic [ZW-1:0] s_in;
    logic [ZW-1:0] c_in;
    logic [ZW-1:0] s;
    logic [ZW-1:0] c;
    logic [ZW-2:0] maj;
    if (k == 0) begin : g_base
      assign s_in = pp_row[0];
      assign c_in = pp_row[1];
    end else begin : g_chain
      assign s_in = g_csa[k-1].s;
      assign c_in = g_csa[k-1].c;
    end
    assign s   = s_in ^ c_in ^ pp_row[k+2];
    assign maj = (s_in[ZW-2:0] & c_in[ZW-2:0]) |
                 (s_in[ZW-2:0] & pp_row[k+2][ZW-2:0]) |
                 (c_in[ZW-2:0] & pp_row[k+2][ZW-2:0]);
    assign c   = {maj, 1'b0};
  end

  assign red_sum   = g_csa[WIDTH-2].s;
  assign red_carry = g_csa[WIDTH-2].c;

  // Final carry-propagate add and optional accumulation of the S1 result.
  always_comb begin
    prod   = s1_sum + s1_carry;
    z_next = prod;
`ifdef CSA_MULT_PIPE_ACC_EN
    acc_next = acc_q;
    if (s1_acc) begin
      acc_next = s1_clr ? prod : (acc_q + prod);
      z_next   = acc_next;
    end
`endif
  end

  // Valid bits, output register and accumulator: reset and advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid  <= 1'b0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_tag   <= '0;
`ifdef CSA_MULT_PIPE_ACC_EN
      acc_q     <= '0;
`endif
    end else if (adv) begin
      s0_valid  <= in_valid;
      s1_valid  <= s0_valid;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_z   <= z_next;
        out_tag <= s1_tag;
`ifdef CSA_MULT_PIPE_ACC_EN
        acc_q   <= acc_next;
`endif
      end
    end
  end

  // Stage data registers: loaded only by a valid beat, held otherwise.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (in_valid) begin
        s0_a      <= in_a;
        s0_b      <= in_b;
        s0_signed <= in_signed;
        s0_tag    <= in_tag;
`ifdef CSA_MULT_PIPE_ACC_EN
        s0_acc    <= in_acc;
        s0_clr    <= in_acc_clr;
`endif
      end
      if (s0_valid) begin
        s1_sum   <= red_sum;
        s1_carry <= red_carry;
        s1_tag   <= s0_tag;
`ifdef CSA_MULT_PIPE_ACC_EN
        s1_acc   <= s0_acc;
        s1_clr   <= s0_clr;
`endif
      end
    end
  end

endmodule
